// File: rtl/mdio_master_22_45.sv
// mdio_master_22_45: Clause 22 / Clause 45 MDIO initiator.
// MDC divided from clk_25m; read bits sampled on the last low-phase cycle.
module mdio_master_22_45 #(
  parameter int MDC_DIV      = 5,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_cl45,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
  } state_t;

  localparam logic [5:0] DIV_LAST = 6'(MDC_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

  state_t      state_q, state_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] sh_q, sh_d, hdr;
  logic        rd_q, rd_d;
  logic        mdc_q, mdc_d;
  logic        mdo_q, mdo_d;
  logic        oe_q, oe_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        err_q, err_d;
  logic        terr_q, terr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] rsh_q, rsh_d;
  logic [1:0]  sync_q, sync_d;
  logic        active, phase_end, bit_end, samp;

  assign hdr = {1'b0, ~cmd_cl45, cmd_op, cmd_phyad,
                cmd_regad, 2'b10, cmd_wdata};
  assign active = state_q inside {S_PRE, S_HDR, S_TA, S_DATA};
  assign phase_end = (div_cnt_q == DIV_LAST);
  assign bit_end = phase_end & mdc_q;
  assign samp = phase_end & ~mdc_q;

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    mdc_d       = mdc_q;
    mdo_d       = mdo_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    err_d       = err_q;
    terr_d      = terr_q;
    rdata_d     = rdata_q;
    rsh_d       = rsh_q;
    sync_d      = {sync_q[0], mdio_i};
    if (active) begin
      div_cnt_d = phase_end ? 6'd0 : div_cnt_q + 6'd1;
      if (phase_end) mdc_d = ~mdc_q;
    end
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          sh_d      = hdr;
          rd_d      = cmd_op[1];
          div_cnt_d = 6'd0;
          bit_cnt_d = 6'd0;
          mdc_d     = 1'b0;
          oe_d      = 1'b1;
          if (PREAMBLE_LEN == 0) begin
            state_d = S_HDR;
            mdo_d   = hdr[31];
          end else begin
            state_d = S_PRE;
            mdo_d   = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = S_HDR;
            bit_cnt_d = 6'd0;
            mdo_d     = sh_q[31];
          end
        end
      end
      S_HDR: begin
        if (bit_end) begin
          sh_d      = sh_q << 1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          mdo_d     = sh_q[30];
          if (bit_cnt_q == 6'd13) begin
            state_d   = S_TA;
            bit_cnt_d = 6'd0;
            if (rd_q) begin
              oe_d  = 1'b0;
              mdo_d = 1'b1;
            end
          end
        end
      end
      S_TA: begin
        if (samp && bit_cnt_q == 6'd1) terr_d = sync_q[1];
        if (bit_end) begin
          sh_d      = sh_q << 1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          mdo_d     = rd_q ? 1'b1 : sh_q[30];
          if (bit_cnt_q == 6'd1) begin
            state_d   = S_DATA;
            bit_cnt_d = 6'd0;
          end
        end
      end
      S_DATA: begin
        if (samp && rd_q) rsh_d = {rsh_q[14:0], sync_q[1]};
        if (bit_end) begin
          sh_d      = sh_q << 1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          mdo_d     = rd_q ? 1'b1 : sh_q[30];
          if (bit_cnt_q == 6'd15) begin
            state_d     = S_DONE;
            bit_cnt_d   = 6'd0;
            oe_d        = 1'b0;
            mdo_d       = 1'b1;
            rsp_valid_d = 1'b1;
            err_d       = rd_q & terr_q;
            if (rd_q) rdata_d = rsh_q;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= 6'd0;
      bit_cnt_q   <= 6'd0;
      sh_q        <= 32'd0;
      rd_q        <= 1'b0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b1;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      terr_q      <= 1'b0;
      rdata_q     <= 16'h0000;
      rsh_q       <= 16'h0000;
      sync_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      rd_q        <= rd_d;
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      terr_q      <= terr_d;
      rdata_q     <= rdata_d;
      rsh_q       <= rsh_d;
      sync_q      <= sync_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdo_q;
  assign mdio_oe   = oe_q;
endmodule

// File: tb/tb_mdio_master_22_45.sv
// tb_mdio_master_22_45: scoreboard bench, two DUTs
// (defaults, and MDC_DIV=3 / no preamble) with an MDIO slave model.
module tb_mdio_master_22_45;
  logic clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  logic        rst_n;
  logic [1:0]  vld;
  logic        cl45;
  logic [1:0]  op;
  logic [4:0]  phy, rad;
  logic [15:0] wd;
  logic [1:0]  rdy, rv, re, mdc, mo, moe;
  logic [15:0] rdat [2];

  longint cyc = 0;
  always @(posedge clk_25m) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit bfm_en = 1'b0;
  logic [15:0] bfm_data = 16'h0;
  logic [15:0] last_rd [2];
  int acc [2] = '{0, 0};

  typedef struct {
    int          inst;
    longint      at;
    logic [15:0] rd;
    logic        err;
    logic [63:0] bits;
    logic [63:0] oem;
    int          n;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk_25m)
    for (int k = 0; k < 2; k++)
      if (vld[k] && rdy[k]) acc[k]++;

  for (genvar i = 0; i < 2; i++) begin : g
    localparam int D  = (i == 0) ? 5 : 3;
    localparam int PL = (i == 0) ? 32 : 0;
    logic        s_oe = 1'b0;
    logic        s_o = 1'b1;
    logic        mi;
    logic        mprev = 1'b0;
    int          rises = 0;
    int          cn = 0;
    logic [63:0] cb = '0;
    logic [63:0] co = '0;
    exp_t        e;

    assign mi = moe[i] ? mo[i] : (s_oe ? s_o : 1'b1);

    mdio_master_22_45 #(.MDC_DIV(D), .PREAMBLE_LEN(PL)) dut (
      .clk_25m  (clk_25m),
      .rst_n    (rst_n),
      .cmd_valid(vld[i]),
      .cmd_ready(rdy[i]),
      .cmd_cl45 (cl45),
      .cmd_op   (op),
      .cmd_phyad(phy),
      .cmd_regad(rad),
      .cmd_wdata(wd),
      .rsp_valid(rv[i]),
      .rsp_rdata(rdat[i]),
      .rsp_err  (re[i]),
      .mdc      (mdc[i]),
      .mdio_o   (mo[i]),
      .mdio_oe  (moe[i]),
      .mdio_i   (mi)
    );

    always @(negedge clk_25m) begin
      if (!rst_n || rdy[i]) begin
        rises = 0;
        s_oe  = 1'b0;
        cn    = 0;
        cb    = '0;
        co    = '0;
      end else begin
        if (mdc[i] && !mprev) begin
          rises++;
          cb = {cb[62:0], mo[i]};
          co = {co[62:0], moe[i]};
          cn++;
        end
        if (!mdc[i] && mprev) begin
          if (rises == PL + 15) begin
            s_oe = bfm_en;
            s_o  = 1'b0;
          end else if (rises >= PL + 16 && rises < PL + 32) begin
            s_o = bfm_data[PL + 31 - rises];
          end else begin
            s_oe = 1'b0;
          end
        end
      end
      mprev = mdc[i];
      if (rv[i]) begin
        chk("rsp_expected", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_inst", i, e.inst);
          chk("rsp_cycle", cyc, e.at);
          chk("rsp_rdata", rdat[i], e.rd);
          chk("rsp_err", re[i], e.err);
          chk("frame_bits_n", cn, e.n);
          chk("frame_mdio_o", cb & e.oem, e.bits & e.oem);
          chk("frame_mdio_oe", co, e.oem);
          chk("done_mdc", mdc[i], 0);
          chk("done_oe", moe[i], 0);
        end
      end
    end
  end

  task automatic send(input int inst, input bit c45,
                      input bit [1:0] o, input bit [4:0] p,
                      input bit [4:0] r, input bit [15:0] w,
                      input bit [31:0] hdr, input bit resp,
                      input bit [15:0] bd, input bit hold,
                      input bit abort);
    int pl, d, n, k, a0;
    bit rd;
    logic [63:0] ones_n, eb, em;
    exp_t x;
    pl = (inst == 0) ? 32 : 0;
    d  = (inst == 0) ? 5 : 3;
    n  = pl + 32;
    rd = o[1];
    k  = 0;
    while (!rdy[inst] && k < 2000) begin
      @(negedge clk_25m);
      k++;
    end
    chk("ready_before_cmd", rdy[inst], 1);
    ones_n = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    eb = (pl == 32) ? {32'hFFFF_FFFF, hdr} : {32'h0, hdr};
    em = rd ? (ones_n & ~64'h3FFFF) : ones_n;
    bfm_en   = resp;
    bfm_data = bd;
    cl45 = c45; op = o; phy = p; rad = r; wd = w;
    vld[inst] = 1'b1;
    x.inst = inst;
    x.at   = cyc + 1 + longint'(n * 2 * d);
    x.rd   = rd ? (resp ? bd : 16'hFFFF) : last_rd[inst];
    x.err  = rd & ~resp;
    x.bits = eb;
    x.oem  = em;
    x.n    = n;
    if (rd) last_rd[inst] = x.rd;
    if (!abort) sb.push_back(x);
    a0 = acc[inst];
    @(negedge clk_25m);
    chk("first_mdc", mdc[inst], 0);
    chk("first_oe", moe[inst], 1);
    chk("first_o", mo[inst], (pl != 0) ? 1'b1 : hdr[31]);
    chk("ready_low", rdy[inst], 0);
    if (hold) begin
      k = 0;
      while (!rv[inst] && k < 3000) begin
        cl45 = 1'($urandom); op = 2'($urandom);
        phy = 5'($urandom); rad = 5'($urandom);
        wd = 16'($urandom);
        @(negedge clk_25m);
        k++;
      end
      chk("hold_reached_done", rv[inst], 1);
    end
    vld[inst] = 1'b0;
    if (abort) begin
      repeat (500) @(negedge clk_25m);
      rst_n = 1'b0;
      #1;
      chk("abort_mdc", mdc[inst], 0);
      chk("abort_oe", moe[inst], 0);
      chk("abort_o", mo[inst], 1);
      chk("abort_rv", rv[inst], 0);
      chk("abort_rdata", rdat[inst], 16'h0);
      chk("abort_ready", rdy[inst], 1);
      repeat (5) @(negedge clk_25m);
      rst_n = 1'b1;
      last_rd[inst] = 16'h0;
      repeat (700) @(negedge clk_25m);
      chk("abort_no_accept", acc[inst] - a0, 1);
    end else begin
      k = 0;
      while (!rdy[inst] && k < 2000) begin
        @(negedge clk_25m);
        k++;
      end
      chk("ready_after_rsp", rdy[inst], 1);
      chk("one_accept", acc[inst] - a0, 1);
    end
  endtask

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    vld = 2'b00;
    cl45 = 1'b0; op = 2'b00; phy = 5'd0; rad = 5'd0; wd = 16'd0;
    last_rd = '{16'h0, 16'h0};
    repeat (3) @(negedge clk_25m);
    vld = 2'b11;
    @(negedge clk_25m);
    for (int i = 0; i < 2; i++) begin
      chk("rst_mdc", mdc[i], 0);
      chk("rst_oe", moe[i], 0);
      chk("rst_o", mo[i], 1);
      chk("rst_rv", rv[i], 0);
      chk("rst_rdata", rdat[i], 16'h0);
      chk("rst_err", re[i], 0);
    end
    vld = 2'b00;
    rst_n = 1'b1;
    @(negedge clk_25m);
    chk("rst_ready0", rdy[0], 1);
    chk("rst_ready1", rdy[1], 1);

    send(0, 0, 2'b01, 5'd3, 5'd1, 16'hA5C3,
         32'b01_01_00011_00001_10_1010_0101_1100_0011,
         0, 16'h0, 0, 0);
    send(0, 0, 2'b10, 5'd3, 5'd2, 16'hDEAD,
         32'b01_10_00011_00010_00_0000_0000_0000_0000,
         1, 16'h1234, 0, 0);
    send(0, 0, 2'b10, 5'd5, 5'd0, 16'h0,
         32'b01_10_00101_00000_00_0000_0000_0000_0000,
         0, 16'h0, 0, 0);
    send(0, 0, 2'b01, 5'd31, 5'd31, 16'h0001,
         32'b01_01_11111_11111_10_0000_0000_0000_0001,
         0, 16'h0, 1, 0);
    send(1, 1, 2'b00, 5'd0, 5'd1, 16'h0010,
         32'b00_00_00000_00001_10_0000_0000_0001_0000,
         0, 16'h0, 0, 0);
    send(1, 1, 2'b10, 5'd0, 5'd1, 16'h0,
         32'b00_10_00000_00001_00_0000_0000_0000_0000,
         1, 16'hBEEF, 0, 0);
    send(1, 1, 2'b11, 5'd2, 5'd3, 16'h0,
         32'b00_11_00010_00011_00_0000_0000_0000_0000,
         1, 16'h8001, 0, 0);
    send(0, 0, 2'b10, 5'd7, 5'd4, 16'h0,
         32'b01_10_00111_00100_00_0000_0000_0000_0000,
         1, 16'h5555, 0, 1);
    send(0, 0, 2'b01, 5'd0, 5'd0, 16'hFFFF,
         32'b01_01_00000_00000_10_1111_1111_1111_1111,
         0, 16'h0, 0, 0);

    repeat (5) @(negedge clk_25m);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mdio_master_22_45.md
# mdio_master_22_45

MDIO station-management initiator for Clause 22 and Clause 45 frames. It accepts one command at a time on a valid/ready interface and generates MDC from the 25 MHz system clock. It serialises the frame onto a tri-state MDIO pin and returns read data plus a no-response flag. It sits in the control subsystem as the master that drives the MDIO slave path of the PHY/ADC device.

## Interface
- MDC_DIV, 5: MDC half-period in clk_25m cycles. Legal range 3..63. Default gives 2.5 MHz MDC.
- PREAMBLE_LEN, 32: number of preamble '1' bits. Legal range 0..32; 0 means preamble suppression.

- clk_25m  input  1  system clock; all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high when idle; a command is accepted when cmd_valid & cmd_ready
- cmd_cl45  input  1  1: ST=00 (Clause 45); 0: ST=01 (Clause 22)
- cmd_op  input  2  OP field, sent as given
- cmd_phyad  input  5  PHYAD / PRTAD
- cmd_regad  input  5  REGAD (CL22) / DEVAD (CL45)
- cmd_wdata  input  16  write data or CL45 address; ignored for reads
- rsp_valid  output  1  one-cycle pulse at frame completion
- rsp_rdata  output  16  read data; holds its value until the next read completes
- rsp_err  output  1  valid with rsp_valid; 1 = read TA second bit not sampled 0
- mdc  output  1  management clock; low when idle
- mdio_o  output  1  MDIO drive value
- mdio_oe  output  1  MDIO output enable
- mdio_i  input  1  MDIO pad input, asynchronous

## Operation
- Read frame: cmd_op[1]=1. This covers CL22 10, CL45 11 and CL45 10. Everything else is a write-type frame, including CL22 write and CL45 address/write. CL22 00/11 are not checked.
- Frame bits, MSB first within each field:
  - PREAMBLE_LEN ones
  - ST, OP, PHYAD, REGAD/DEVAD
  - TA (2 bits)
  - DATA (16 bits)
- Total frame bits: N = PREAMBLE_LEN + 32.
- Command fields are latched into a 32-bit shift register on acceptance.
- TA and DATA drive:
  - Write-type frame: TA drives "10", then cmd_wdata.
  - Read frame: mdio_oe=0 for both TA bits and all 16 DATA bits.
- mdio_i passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Read sampling point: the last cycle of a bit's low phase, i.e. the cycle in which mdc is driven 0->1.
  - TA bit 2 is sampled at this point; if it is not 0, rsp_err is set.
  - DATA bits shift into the rdata shift register MSB first at the same point.
- rsp_rdata is loaded only at completion of a read. rsp_err is 0 for write-type frames.
- States:
  - IDLE -> PRE on accept, or directly to HDR if PREAMBLE_LEN=0.
  - PRE -> HDR after PREAMBLE_LEN bits.
  - HDR (14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE (1 cycle) -> IDLE.
- Counters:
  - div_cnt: 6-bit, counts 0..MDC_DIV-1, selects the MDC phase.
  - bit_cnt: 6-bit, counts bits within the current state.
- cmd_valid is ignored outside IDLE. No queueing.

## Timing
- Reset values:
  - cmd_ready=1 (state IDLE)
  - mdc=0, mdio_o=1, mdio_oe=0
  - rsp_valid=0, rsp_rdata=16'h0000, rsp_err=0
- Reset asserted mid-frame: all outputs take their reset values immediately. The frame is abandoned and no rsp_valid is produced.
- Bit period is 2*MDC_DIV cycles: MDC_DIV cycles with mdc low, then MDC_DIV cycles with mdc high.
- mdio_o and mdio_oe change only in the first cycle of a low phase, i.e. on the cycle mdc falls. On the first bit this is T+1.
- Accept cycle T:
  - cmd_ready=0 from T+1.
  - The first bit starts at T+1 with mdc=0, mdio_oe=1 and the first bit value on mdio_o.
- rsp_valid is high at cycle T+1+N*2*MDC_DIV. This is the DONE cycle: mdc=0, mdio_oe=0.
- cmd_ready=1 from the following cycle.
- With default parameters, rsp_valid is at T+641 and cmd_ready returns at T+642.
- After the last DATA bit's high phase, mdio_oe=0 and mdio_o=1 until the next frame.

## Test plan
- Reset: hold rst_n low, pulse cmd_valid -> mdc=0, mdio_oe=0, mdio_o=1, rsp_valid=0, rsp_rdata=0. Release rst_n -> cmd_ready=1.
- CL22 write: phyad=3, regad=1, wdata=16'hA5C3, defaults.
  - mdio_o per bit = 32×'1', then 01 01 00011 00001 10 1010010111000011.
  - mdio_oe=1 for the whole frame.
  - rsp_valid exactly at T+641 with rsp_err=0.
- CL22 read (op=10): BFM slave releases for TA bit 1, drives 0 for TA bit 2, then 16'h1234.
  - mdio_oe falls at the first TA bit.
  - rsp_rdata=16'h1234, rsp_err=0.
- Read with no responder (mdio_i pulled high) -> rsp_rdata=16'hFFFF, rsp_err=1.
- CL45, PREAMBLE_LEN=0, MDC_DIV=3:
  - Address frame op=00, devad=1, wdata=16'h0010, then read-increment op=10 with the BFM returning 16'hBEEF.
  - ST bits = 00; each frame is 32 bits.
  - rsp_valid at T+1+192; second response rsp_rdata=16'hBEEF.
- Robustness:
  - cmd_valid held high with changing fields during a frame -> the frame is unaffected and only one command is accepted per frame.
  - rst_n asserted mid-DATA -> outputs reset immediately, with no rsp_valid.
